// File: rtl/inst_axi_rd_bridge.sv
// -----------------------------------------------------------------------------
// inst_axi_rd_bridge
//
// Bridges a simple SRAM-style instruction fetch port onto an AXI3/AXI4 read
// channel. Each accepted fetch becomes one single-beat AXI read (arlen=0).
// Responses come back in order, so the R channel is matched to requests only
// by counting how many reads are still outstanding.
//
// Parameters
//   MAX_OUT   maximum accepted-but-unreturned reads (1..3)
//   ARID_VAL  constant ID driven on arid
//
// Ports
//   clk, reset              clock; synchronous active-high reset
//   inst_sram_en/wr/size/addr   fetch request (wr must be 0 to be accepted)
//   inst_sram_addr_ok       request accepted this cycle (combinational)
//   inst_sram_data_ok       read data valid this cycle (combinational)
//   inst_sram_rdata         returned instruction word (pass-through of rdata)
//   inst_sram_rerr          returned beat had a non-OKAY response
//   ar*                     AXI read address channel
//   rid, rdata, rresp, rlast, rvalid, rready   AXI read data channel
// -----------------------------------------------------------------------------
module inst_axi_rd_bridge #(
  parameter int         MAX_OUT  = 2,
  parameter logic [3:0] ARID_VAL = 4'd0
) (
  input  logic        clk,
  input  logic        reset,

  // Instruction SRAM-like fetch interface
  input  logic        inst_sram_en,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [31:0] inst_sram_addr,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  output logic        inst_sram_rerr,

  // AXI read address channel
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,

  // AXI read data channel
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  localparam logic [1:0] LP_MAX_OUT = 2'(MAX_OUT);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic        r_ar_pend;   // an AR is waiting for arready
  logic [31:0] r_ar_addr;   // captured fetch address
  logic [1:0]  r_ar_size;   // captured log2 byte count
  logic [1:0]  r_out_cnt;   // accepted reads whose R beat has not returned

  logic [1:0]  w_out_cnt_nxt;
  logic        w_addr_ok;
  logic        w_rready;
  logic        w_ar_hs;
  logic        w_r_hs;

  // rid and rlast carry no information here: responses are in order and every
  // burst is a single beat. Folded into a deliberately unused net.
  logic        w_unused_ok;
  assign w_unused_ok = ^{rid, rlast};

  // ---------------------------------------------------------------------------
  // Handshakes
  // ---------------------------------------------------------------------------
  // A new request is blocked while the previous AR is still pending, which
  // also rules out accepting in the same cycle as the AR handshake. Outputs are
  // gated with reset so they are quiet for the whole reset cycle, even before
  // the first edge has cleared the state.
  assign w_addr_ok = !reset && inst_sram_en && !inst_sram_wr && !r_ar_pend
                     && (r_out_cnt < LP_MAX_OUT);
  assign w_rready  = !reset && (r_out_cnt != 2'd0);
  assign w_ar_hs   = r_ar_pend && arready;
  assign w_r_hs    = rvalid && w_rready;

  // ---------------------------------------------------------------------------
  // Outstanding-read counter next value
  // ---------------------------------------------------------------------------
  // Overflow cannot occur (addr_ok requires out_cnt < MAX_OUT) and underflow
  // cannot occur (rready requires out_cnt != 0), so plain +/-1 is safe.
  always_comb begin
    // NOTE: default assignment first so every path drives the signal; without
    // it a combinational block infers a latch.
    w_out_cnt_nxt = r_out_cnt;
    unique case ({w_addr_ok, w_r_hs})
      2'b10:   w_out_cnt_nxt = r_out_cnt + 2'd1;
      2'b01:   w_out_cnt_nxt = r_out_cnt - 2'd1;
      default: w_out_cnt_nxt = r_out_cnt;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sequential state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all registered state so every
    // register samples the pre-edge values regardless of statement order.
    if (reset) begin
      r_ar_pend <= 1'b0;
      r_ar_addr <= 32'd0;
      r_ar_size <= 2'd0;
      r_out_cnt <= 2'd0;
    end else begin
      // Address/size are only loaded on acceptance, so they stay stable for
      // as long as arvalid is held without arready.
      if (w_addr_ok) begin
        r_ar_pend <= 1'b1;
        r_ar_addr <= inst_sram_addr;
        r_ar_size <= inst_sram_size;
      end else if (w_ar_hs) begin
        r_ar_pend <= 1'b0;
      end
      r_out_cnt <= w_out_cnt_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign inst_sram_addr_ok = w_addr_ok;
  assign inst_sram_data_ok = w_r_hs;
  assign inst_sram_rdata   = rdata;
  assign inst_sram_rerr    = w_r_hs && (rresp != 2'b00);

  assign arid    = ARID_VAL;
  assign araddr  = r_ar_addr;
  assign arlen   = 8'd0;
  assign arsize  = {1'b0, r_ar_size};
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;
  assign arvalid = r_ar_pend && !reset;

  assign rready  = w_rready;

endmodule

// File: tb/tb_inst_axi_rd_bridge.sv
// -----------------------------------------------------------------------------
// tb_inst_axi_rd_bridge
//
// Directed bench for inst_axi_rd_bridge (MAX_OUT=2, ARID_VAL=4'd0). Inputs are
// driven 1 time unit after the rising edge; combinational outputs are sampled
// 1 unit later, well before the next edge.
// -----------------------------------------------------------------------------
module tb_inst_axi_rd_bridge;

  logic        clk;
  logic        reset;
  logic        inst_sram_en;
  logic        inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        inst_sram_rerr;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  int checks;
  int errors;

  inst_axi_rd_bridge #(.MAX_OUT(2), .ARID_VAL(4'd0)) dut (
    .clk               (clk),
    .reset             (reset),
    .inst_sram_en      (inst_sram_en),
    .inst_sram_wr      (inst_sram_wr),
    .inst_sram_size    (inst_sram_size),
    .inst_sram_addr    (inst_sram_addr),
    .inst_sram_addr_ok (inst_sram_addr_ok),
    .inst_sram_data_ok (inst_sram_data_ok),
    .inst_sram_rdata   (inst_sram_rdata),
    .inst_sram_rerr    (inst_sram_rerr),
    .arid              (arid),
    .araddr            (araddr),
    .arlen             (arlen),
    .arsize            (arsize),
    .arburst           (arburst),
    .arlock            (arlock),
    .arcache           (arcache),
    .arprot            (arprot),
    .arvalid           (arvalid),
    .arready           (arready),
    .rid               (rid),
    .rdata             (rdata),
    .rresp             (rresp),
    .rlast             (rlast),
    .rvalid            (rvalid),
    .rready            (rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Settle combinational outputs after driving inputs.
  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    inst_sram_en   = 1'b0;
    inst_sram_wr   = 1'b0;
    inst_sram_size = 2'd0;
    inst_sram_addr = 32'd0;
    arready        = 1'b0;
    rid            = 4'd0;
    rdata          = 32'd0;
    rresp          = 2'b00;
    rlast          = 1'b1;
    rvalid         = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    // Try to provoke activity while reset is held.
    inst_sram_en   = 1'b1;
    inst_sram_addr = 32'h1234_5678;
    inst_sram_size = 2'd2;
    rvalid         = 1'b1;
    rresp          = 2'b10;
    arready        = 1'b1;
    tick();
    settle();
    checks++;
    if ({inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rerr, arvalid, rready} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_ctrl: {addr_ok,data_ok,rerr,arvalid,rready} got %b want 00000",
               {inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rerr, arvalid, rready});
    end
    checks++;
    if ({araddr, arsize} !== 35'd0) begin
      errors++;
      $display("FAIL reset_ar_regs: araddr=%h arsize=%b want 0/000", araddr, arsize);
    end
    checks++;
    if ({arid, arlen, arburst, arlock, arcache, arprot} !== {4'd0, 8'd0, 2'b01, 2'b00, 4'd0, 3'd0}) begin
      errors++;
      $display("FAIL const_ar: arid=%h arlen=%h arburst=%b arlock=%b arcache=%h arprot=%b",
               arid, arlen, arburst, arlock, arcache, arprot);
    end
    // Leave reset with nothing driven: still quiet.
    idle_inputs();
    reset = 1'b0;
    tick();
    checks++;
    if ({arvalid, rready} !== 2'b00) begin
      errors++;
      $display("FAIL post_reset_idle: arvalid=%b rready=%b want 0 0", arvalid, rready);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_single_fetch();
    do_reset();
    // cycle 0: request
    inst_sram_en   = 1'b1;
    inst_sram_addr = 32'h1fc0_0000;
    inst_sram_size = 2'd2;
    arready        = 1'b1;
    settle();
    checks++;
    if (inst_sram_addr_ok !== 1'b1) begin
      errors++;
      $display("FAIL single_addr_ok: got %b want 1", inst_sram_addr_ok);
    end
    tick();
    // cycle 1: en dropped, AR must still go out
    inst_sram_en   = 1'b0;
    inst_sram_addr = 32'hdead_beef;
    settle();
    checks++;
    if ({arvalid, araddr, arsize} !== {1'b1, 32'h1fc0_0000, 3'b010}) begin
      errors++;
      $display("FAIL single_ar: arvalid=%b araddr=%h arsize=%b want 1 1fc00000 010",
               arvalid, araddr, arsize);
    end
    tick();
    // cycle 2: AR done, waiting on R
    settle();
    checks++;
    if ({arvalid, rready, inst_sram_data_ok} !== 3'b010) begin
      errors++;
      $display("FAIL single_wait: {arvalid,rready,data_ok} got %b want 010",
               {arvalid, rready, inst_sram_data_ok});
    end
    tick();
    // cycle 3: R beat
    rvalid = 1'b1;
    rdata  = 32'h3c1a_0000;
    rresp  = 2'b00;
    settle();
    checks++;
    if ({inst_sram_data_ok, inst_sram_rerr, inst_sram_rdata} !== {1'b1, 1'b0, 32'h3c1a_0000}) begin
      errors++;
      $display("FAIL single_data: data_ok=%b rerr=%b rdata=%h want 1 0 3c1a0000",
               inst_sram_data_ok, inst_sram_rerr, inst_sram_rdata);
    end
    tick();
    rvalid = 1'b0;
    settle();
    checks++;
    if (rready !== 1'b0) begin
      errors++;
      $display("FAIL single_drained: rready got %b want 0", rready);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_ar_backpressure();
    do_reset();
    arready        = 1'b0;
    inst_sram_en   = 1'b1;
    inst_sram_addr = 32'h0000_1000;
    inst_sram_size = 2'd2;
    settle();
    checks++;
    if (inst_sram_addr_ok !== 1'b1) begin
      errors++;
      $display("FAIL bp_first_accept: addr_ok got %b want 1", inst_sram_addr_ok);
    end
    tick();
    // Keep requesting a different address during the stall.
    inst_sram_addr = 32'h0000_2000;
    inst_sram_size = 2'd1;
    for (int i = 0; i < 5; i++) begin
      settle();
      checks++;
      if ({arvalid, araddr, arsize, inst_sram_addr_ok} !== {1'b1, 32'h0000_1000, 3'b010, 1'b0}) begin
        errors++;
        $display("FAIL bp_hold[%0d]: arvalid=%b araddr=%h arsize=%b addr_ok=%b want 1 00001000 010 0",
                 i, arvalid, araddr, arsize, inst_sram_addr_ok);
      end
      tick();
    end
    // Handshake cycle: still no same-cycle accept.
    arready = 1'b1;
    settle();
    checks++;
    if ({arvalid, inst_sram_addr_ok} !== 2'b10) begin
      errors++;
      $display("FAIL bp_hs_cycle: {arvalid,addr_ok} got %b want 10", {arvalid, inst_sram_addr_ok});
    end
    tick();
    settle();
    checks++;
    if ({arvalid, inst_sram_addr_ok} !== 2'b01) begin
      errors++;
      $display("FAIL bp_next_accept: {arvalid,addr_ok} got %b want 01", {arvalid, inst_sram_addr_ok});
    end
    tick();
    inst_sram_en = 1'b0;
    settle();
    checks++;
    if ({arvalid, araddr, arsize} !== {1'b1, 32'h0000_2000, 3'b001}) begin
      errors++;
      $display("FAIL bp_second_ar: arvalid=%b araddr=%h arsize=%b want 1 00002000 001",
               arvalid, araddr, arsize);
    end
    tick();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_outstanding_limit();
    do_reset();
    arready        = 1'b1;
    inst_sram_en   = 1'b1;
    inst_sram_size = 2'd2;
    inst_sram_addr = 32'h0000_0100;
    tick();                      // accept #1
    inst_sram_addr = 32'h0000_0104;
    tick();                      // AR #1 handshake, addr_ok blocked by pending AR
    settle();
    checks++;
    if (inst_sram_addr_ok !== 1'b1) begin
      errors++;
      $display("FAIL lim_second_accept: addr_ok got %b want 1", inst_sram_addr_ok);
    end
    tick();                      // accept #2
    tick();                      // AR #2 handshake
    // Now two outstanding, en still high, no R traffic.
    for (int i = 0; i < 3; i++) begin
      settle();
      checks++;
      if ({inst_sram_addr_ok, arvalid, rready} !== 3'b001) begin
        errors++;
        $display("FAIL lim_full[%0d]: {addr_ok,arvalid,rready} got %b want 001",
                 i, {inst_sram_addr_ok, arvalid, rready});
      end
      tick();
    end
    // One beat returns: accept still blocked this cycle (count is 2 until edge).
    rvalid = 1'b1;
    rdata  = 32'h0000_0aaa;
    settle();
    checks++;
    if ({inst_sram_data_ok, inst_sram_addr_ok} !== 2'b10) begin
      errors++;
      $display("FAIL lim_return: {data_ok,addr_ok} got %b want 10", {inst_sram_data_ok, inst_sram_addr_ok});
    end
    tick();
    rvalid = 1'b0;
    settle();
    checks++;
    if (inst_sram_addr_ok !== 1'b1) begin
      errors++;
      $display("FAIL lim_reopen: addr_ok got %b want 1", inst_sram_addr_ok);
    end
    tick();
    inst_sram_en = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_simultaneous();
    do_reset();
    arready        = 1'b1;
    inst_sram_en   = 1'b1;
    inst_sram_size = 2'd2;
    inst_sram_addr = 32'h0000_0200;
    tick();                      // accept, out_cnt=1
    inst_sram_en = 1'b0;
    tick();                      // AR handshake
    // out_cnt=1: new accept and a return in the same cycle.
    inst_sram_en   = 1'b1;
    inst_sram_addr = 32'h0000_0204;
    rvalid         = 1'b1;
    rdata          = 32'h1111_2222;
    settle();
    checks++;
    if ({inst_sram_addr_ok, inst_sram_data_ok} !== 2'b11) begin
      errors++;
      $display("FAIL sim_both: {addr_ok,data_ok} got %b want 11", {inst_sram_addr_ok, inst_sram_data_ok});
    end
    tick();
    inst_sram_en = 1'b0;
    rvalid       = 1'b0;
    tick();                      // AR handshake for the second request
    // Exactly one outstanding: one beat must empty the counter.
    settle();
    checks++;
    if (rready !== 1'b1) begin
      errors++;
      $display("FAIL sim_cnt_nonzero: rready got %b want 1", rready);
    end
    rvalid = 1'b1;
    rdata  = 32'h3333_4444;
    tick();
    rvalid = 1'b0;
    settle();
    checks++;
    if (rready !== 1'b0) begin
      errors++;
      $display("FAIL sim_cnt_one: rready after one beat got %b want 0", rready);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_error_and_write();
    do_reset();
    // Stray beat with nothing outstanding: not accepted, no error flagged.
    rvalid = 1'b1;
    rresp  = 2'b10;
    settle();
    checks++;
    if ({rready, inst_sram_data_ok, inst_sram_rerr} !== 3'b000) begin
      errors++;
      $display("FAIL stray_beat: {rready,data_ok,rerr} got %b want 000",
               {rready, inst_sram_data_ok, inst_sram_rerr});
    end
    tick();
    rvalid         = 1'b0;
    arready        = 1'b1;
    inst_sram_en   = 1'b1;
    inst_sram_addr = 32'h0000_0300;
    tick();                      // accept
    inst_sram_en = 1'b0;
    tick();                      // AR handshake
    rvalid = 1'b1;
    rresp  = 2'b10;
    rdata  = 32'h0bad_0bad;
    settle();
    checks++;
    if ({inst_sram_data_ok, inst_sram_rerr} !== 2'b11) begin
      errors++;
      $display("FAIL err_beat: {data_ok,rerr} got %b want 11", {inst_sram_data_ok, inst_sram_rerr});
    end
    tick();
    rvalid = 1'b0;
    rresp  = 2'b00;
    settle();
    checks++;
    if (rready !== 1'b0) begin
      errors++;
      $display("FAIL err_completes: rready got %b want 0", rready);
    end
    // Write requests are never accepted.
    inst_sram_en   = 1'b1;
    inst_sram_wr   = 1'b1;
    inst_sram_addr = 32'h0000_0400;
    for (int i = 0; i < 10; i++) begin
      settle();
      checks++;
      if ({inst_sram_addr_ok, arvalid} !== 2'b00) begin
        errors++;
        $display("FAIL write_blocked[%0d]: {addr_ok,arvalid} got %b want 00",
                 i, {inst_sram_addr_ok, arvalid});
      end
      tick();
    end
    inst_sram_en = 1'b0;
    inst_sram_wr = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_midflight();
    do_reset();
    arready        = 1'b1;
    inst_sram_en   = 1'b1;
    inst_sram_size = 2'd2;
    inst_sram_addr = 32'h0000_0500;
    tick();                      // accept #1
    tick();                      // AR #1 handshake
    arready        = 1'b0;
    inst_sram_addr = 32'h0000_0504;
    tick();                      // accept #2, AR now stalled
    inst_sram_en = 1'b0;
    settle();
    checks++;
    if ({arvalid, rready} !== 2'b11) begin
      errors++;
      $display("FAIL mid_setup: {arvalid,rready} got %b want 11", {arvalid, rready});
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    settle();
    checks++;
    if ({arvalid, rready} !== 2'b00) begin
      errors++;
      $display("FAIL mid_cleared: {arvalid,rready} got %b want 00", {arvalid, rready});
    end
    // Late R beat must be ignored.
    rvalid = 1'b1;
    rdata  = 32'h5555_5555;
    settle();
    checks++;
    if (inst_sram_data_ok !== 1'b0) begin
      errors++;
      $display("FAIL mid_late_beat: data_ok got %b want 0", inst_sram_data_ok);
    end
    tick();
    rvalid = 1'b0;
    // Counter at 0: a fresh request is accepted.
    inst_sram_en   = 1'b1;
    inst_sram_addr = 32'h0000_0600;
    settle();
    checks++;
    if (inst_sram_addr_ok !== 1'b1) begin
      errors++;
      $display("FAIL mid_fresh_accept: addr_ok got %b want 1", inst_sram_addr_ok);
    end
    tick();
    inst_sram_en = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    checks = 0;
    errors = 0;
    idle_inputs();
    reset = 1'b1;
    test_reset();
    test_single_fetch();
    test_ar_backpressure();
    test_outstanding_limit();
    test_simultaneous();
    test_error_and_write();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_axi_rd_bridge.md
INST_AXI_RD_BRIDGE -- requirements
Module: inst_axi_rd_bridge

Interface
REQ-001 Parameter: MAX_OUT, 2, maximum accepted-but-unreturned reads; legal range 1..3.
REQ-002 Parameter: ARID_VAL, 4'd0, constant ID driven on arid.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 inst_sram_en  input  1  fetch request valid.
REQ-006 inst_sram_wr  input  1  write flag; must be 0 for a request to be accepted.
REQ-007 inst_sram_size  input  2  log2 byte count.
REQ-008 inst_sram_addr  input  32  physical fetch address.
REQ-009 inst_sram_addr_ok  output  1  request accepted this cycle.
REQ-010 inst_sram_data_ok  output  1  read data valid this cycle.
REQ-011 inst_sram_rdata  output  32  returned instruction word.
REQ-012 inst_sram_rerr  output  1  returned beat had non-OKAY response.
REQ-013 arid  output  4  read ID.
REQ-014 araddr  output  32  read address.
REQ-015 arlen  output  8  burst length - 1.
REQ-016 arsize  output  3  beat size.
REQ-017 arburst  output  2  burst type.
REQ-018 arlock  output  2  lock type.
REQ-019 arcache  output  4  cache attributes.
REQ-020 arprot  output  3  protection attributes.
REQ-021 arvalid  output  1  AR valid.
REQ-022 arready  input  1  AR ready.
REQ-023 rid  input  4  read ID; ignored, responses are in order.
REQ-024 rdata  input  32  read data.
REQ-025 rresp  input  2  read response.
REQ-026 rlast  input  1  last beat; ignored, always 1 for arlen=0.
REQ-027 rvalid  input  1  R valid.
REQ-028 rready  output  1  R ready.

Function
REQ-029 Constant outputs: arid=ARID_VAL, arlen=0, arburst=2'b01, arlock=0, arcache=0, arprot=0.
REQ-030 State: ar_pend (1 bit), ar_addr_r (32), ar_size_r (2), out_cnt (2).
REQ-031 addr_ok is combinational: en && !wr && !ar_pend && (out_cnt < MAX_OUT).
REQ-032 On addr_ok: next cycle ar_pend=1, ar_addr_r=inst_sram_addr, ar_size_r=inst_sram_size.
REQ-033 arvalid=ar_pend, araddr=ar_addr_r, arsize={1'b0,ar_size_r}; fields stay stable while arvalid=1 && arready=0.
REQ-034 On arvalid && arready: ar_pend clears next cycle; same-cycle addr_ok is not allowed, so at most one request is accepted per two cycles.
REQ-035 out_cnt: +1 on addr_ok; -1 on rvalid && rready; both in the same cycle leaves it unchanged; it never exceeds MAX_OUT or wraps below 0.
REQ-036 rready = (out_cnt != 0); an R beat with out_cnt==0 is not accepted.
REQ-037 data_ok = rvalid && rready, combinational; rdata is passed through; rerr = data_ok && (rresp != 2'b00).
REQ-038 Data returns in acceptance order; an error beat still counts as a completed read.
REQ-039 en && wr: addr_ok stays 0 indefinitely and no AXI traffic results.
REQ-040 Deasserting en after addr_ok has no effect on the pending AR or on the outstanding read.
REQ-041 The block has no cancel input; the consumer discards unwanted data_ok beats, and every accepted request produces exactly one data_ok.

Reset
REQ-042 While reset=1: ar_pend=0, out_cnt=0, ar_addr_r=0, ar_size_r=0; addr_ok, data_ok, rerr, arvalid and rready are all 0.
REQ-043 Reset asserted mid-transaction drops all pending and outstanding state; R beats arriving after reset are not accepted.

Verification
REQ-044 Single fetch: en=1, addr=0x1fc00000, size=2, arready=1 -> addr_ok in cycle 0; arvalid with araddr=0x1fc00000, arsize=3'b010 in cycle 1; rvalid with rdata=0x3c1a0000 in cycle 3 -> data_ok=1 and rdata=0x3c1a0000 in cycle 3.
REQ-045 AR backpressure: arready=0 for 5 cycles -> arvalid held and araddr unchanged for 5 cycles; no further addr_ok in that time; on arready=1, one handshake, then addr_ok allowed next cycle.
REQ-046 Outstanding limit (MAX_OUT=2): two accepted requests, rvalid=0 -> out_cnt=2 and addr_ok=0 while en=1; one R beat -> addr_ok=1 on the following cycle.
REQ-047 Simultaneous accept and return: out_cnt=1, addr_ok and data_ok in the same cycle -> out_cnt stays 1.
REQ-048 Error and write cases: rresp=2'b10 on a beat -> data_ok=1 and rerr=1; en=1 with wr=1 for 10 cycles -> addr_ok=0 and arvalid=0 throughout.
REQ-049 Reset mid-flight: out_cnt=2 and ar_pend=1, assert reset for 1 cycle -> the next cycle shows arvalid=0, rready=0 and out_cnt=0.
